branch_resolve: RTL and testbench

- Branch resolution stage directly downstream of the ALU compare units (LEZ/GTZ/EQ family).
- Consumes the compare unit's Z flag for the branch in EX and decides taken/not-taken.
- For taken branches, drives a held redirect request to the fetch stage with a valid/ready handshake, then squashes younger instructions for a fixed number of cycles.
- Keeps saturating branch statistics counters.

---
 rtl/branch_resolve.sv | 94 +++++++++
 tb/tb_branch_resolve.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution: decides taken/not-taken from the compare Z flag,
// issues a held redirect to fetch, then squashes younger instructions.
module branch_resolve #(
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_cmp_z,
  input  logic [PC_WIDTH-1:0]  ex_target,
  output logic                 ex_stall,
  output logic                 redir_valid,
  output logic [PC_WIDTH-1:0]  redir_pc,
  input  logic                 redir_ready,
  output logic                 flush,
  output logic                 misalign,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  localparam int FW =
    (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(1);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  state_t        state;
  logic [FW-1:0] fcnt;
  logic          br;

  assign br       = ex_valid & ex_is_branch;
  assign ex_stall = br & (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      branch_cnt  <= '0;
      taken_cnt   <= '0;
      fcnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (br) begin
            if (branch_cnt != '1)
              branch_cnt <= branch_cnt + 1'b1;
            if (!ex_cmp_z) begin
              if (taken_cnt != '1)
                taken_cnt <= taken_cnt + 1'b1;
              redir_pc    <= {ex_target[PC_WIDTH-1:2], 2'b00};
              misalign    <= misalign | (ex_target[1:0] != 2'b00);
              redir_valid <= 1'b1;
              flush       <= 1'b1;
              state       <= REDIRECT;
            end
          end
        end
        REDIRECT: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              flush <= 1'b0;
              state <= IDLE;
            end else begin
              fcnt  <= FLUSH_INIT;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Counter reading 1 is the last flush cycle.
          fcnt <= fcnt - 1'b1;
          if (fcnt == FLUSH_LAST) begin
            flush <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: per-cycle vector table on the
// default build plus a counter-saturation run on a 4-bit, no-flush build.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_is_branch, ex_cmp_z, redir_ready;
  logic [31:0] ex_target;
  logic        ex_stall, redir_valid, flush, misalign;
  logic [31:0] redir_pc;
  logic [15:0] branch_cnt, taken_cnt;

  logic        s_valid, s_is_branch, s_cmp_z, s_ready;
  logic [31:0] s_target;
  logic        s_stall, s_rvalid, s_flush, s_misalign;
  logic [31:0] s_pc;
  logic [3:0]  s_bcnt, s_tcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_cmp_z(ex_cmp_z), .ex_target(ex_target),
    .ex_stall(ex_stall), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .redir_ready(redir_ready),
    .flush(flush), .misalign(misalign),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve #(.PC_WIDTH(32), .FLUSH_CYCLES(0), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset),
    .ex_valid(s_valid), .ex_is_branch(s_is_branch),
    .ex_cmp_z(s_cmp_z), .ex_target(s_target),
    .ex_stall(s_stall), .redir_valid(s_rvalid),
    .redir_pc(s_pc), .redir_ready(s_ready),
    .flush(s_flush), .misalign(s_misalign),
    .branch_cnt(s_bcnt), .taken_cnt(s_tcnt)
  );

  typedef struct {
    logic        rst, v, b, z;
    logic [31:0] tgt;
    logic        rdy;
    logic        st, rv;
    logic [31:0] pc;
    logic        cpc, fl, mis;
    logic [15:0] bc, tc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic rst, logic v, logic b, logic z, logic [31:0] tgt, logic rdy,
    logic st, logic rv, logic [31:0] pc, logic cpc, logic fl,
    logic mis, logic [15:0] bc, logic [15:0] tc);
    vec_t r;
    r.rst = rst; r.v = v; r.b = b; r.z = z; r.tgt = tgt; r.rdy = rdy;
    r.st = st; r.rv = rv; r.pc = pc; r.cpc = cpc; r.fl = fl;
    r.mis = mis; r.bc = bc; r.tc = tc;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h",
               name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; ex_is_branch = 0; ex_cmp_z = 0;
    ex_target = '0; redir_ready = 0;
    s_valid = 0; s_is_branch = 0; s_cmp_z = 0;
    s_target = '0; s_ready = 0;

    // rst v b z tgt rdy | stall rv pc cpc fl mis bc tc
    tv.push_back(mk(0,0,0,0,32'h0,0,           0,0,32'h0,1,0,0,0,0));
    tv.push_back(mk(0,1,1,1,32'h0000_1000,0,   0,0,32'h0,1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,32'h0,0,           0,0,32'h0,1,0,0,1,0));
    tv.push_back(mk(0,0,1,0,32'h0000_3000,0,   0,0,32'h0,1,0,0,1,0));
    tv.push_back(mk(0,1,0,0,32'h0000_3000,0,   0,0,32'h0,1,0,0,1,0));
    tv.push_back(mk(0,1,1,0,32'h0040_0020,0,   0,0,32'h0,1,0,0,1,0));
    tv.push_back(mk(0,0,0,0,32'h0,1,   0,1,32'h0040_0020,1,1,0,2,1));
    tv.push_back(mk(0,0,0,0,32'h0,0,           0,0,32'h0,0,1,0,2,1));
    tv.push_back(mk(0,1,1,1,32'h0000_0100,0,   1,0,32'h0,0,1,0,2,1));
    tv.push_back(mk(0,1,1,1,32'h0000_0100,0,   0,0,32'h0,0,0,0,2,1));
    tv.push_back(mk(0,0,0,0,32'h0,0,           0,0,32'h0,0,0,0,3,1));
    tv.push_back(mk(0,1,1,0,32'h0000_1006,0,   0,0,32'h0,0,0,0,3,1));
    tv.push_back(mk(0,0,0,0,32'h0,0,   0,1,32'h0000_1004,1,1,1,4,2));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,1,1,0,32'h0000_2000,0,
                      1,1,32'h0000_1004,1,1,1,4,2));
    tv.push_back(mk(0,1,1,0,32'h0000_2000,1,
                    1,1,32'h0000_1004,1,1,1,4,2));
    tv.push_back(mk(0,1,1,0,32'h0000_2000,0,   1,0,32'h0,0,1,1,4,2));
    tv.push_back(mk(0,1,1,0,32'h0000_2000,0,   1,0,32'h0,0,1,1,4,2));
    tv.push_back(mk(0,1,1,0,32'h0000_2000,0,   0,0,32'h0,0,0,1,4,2));
    tv.push_back(mk(0,0,0,0,32'h0,0,   0,1,32'h0000_2000,1,1,1,5,3));
    tv.push_back(mk(1,0,0,0,32'h0,0,   0,1,32'h0000_2000,1,1,1,5,3));
    tv.push_back(mk(0,0,0,0,32'h0,1,           0,0,32'h0,1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,32'h0,0,           0,0,32'h0,1,0,0,0,0));

    repeat (2) @(posedge clk);

    foreach (tv[i]) begin
      @(negedge clk);
      reset        = tv[i].rst;
      ex_valid     = tv[i].v;
      ex_is_branch = tv[i].b;
      ex_cmp_z     = tv[i].z;
      ex_target    = tv[i].tgt;
      redir_ready  = tv[i].rdy;
      #1;
      chk("ex_stall", i, 32'(ex_stall), 32'(tv[i].st));
      chk("redir_valid", i, 32'(redir_valid), 32'(tv[i].rv));
      if (tv[i].cpc)
        chk("redir_pc", i, redir_pc, tv[i].pc);
      chk("flush", i, 32'(flush), 32'(tv[i].fl));
      chk("misalign", i, 32'(misalign), 32'(tv[i].mis));
      chk("branch_cnt", i, 32'(branch_cnt), 32'(tv[i].bc));
      chk("taken_cnt", i, 32'(taken_cnt), 32'(tv[i].tc));
    end

    // Saturation on the 4-bit build; FLUSH_CYCLES=0 returns to IDLE
    // directly on the handshake.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_ready     = 0;
      s_valid     = 1;
      s_is_branch = 1;
      s_cmp_z     = 0;
      s_target    = 32'(i * 4);
      #1;
      chk("sat_idle_rv", i, 32'(s_rvalid), 32'd0);
      chk("sat_idle_flush", i, 32'(s_flush), 32'd0);
      chk("sat_stall", i, 32'(s_stall), 32'd0);
      chk("sat_bcnt", i, 32'(s_bcnt), (i > 15) ? 32'd15 : 32'(i));
      chk("sat_tcnt", i, 32'(s_tcnt), (i > 15) ? 32'd15 : 32'(i));
      @(negedge clk);
      s_valid = 0;
      s_ready = 1;
      #1;
      chk("sat_rv", i, 32'(s_rvalid), 32'd1);
      chk("sat_flush", i, 32'(s_flush), 32'd1);
      chk("sat_pc", i, s_pc, 32'(i * 4));
    end
    @(negedge clk);
    s_ready = 0;
    #1;
    chk("sat_end_rv", 17, 32'(s_rvalid), 32'd0);
    chk("sat_end_flush", 17, 32'(s_flush), 32'd0);
    chk("sat_end_bcnt", 17, 32'(s_bcnt), 32'd15);
    chk("sat_end_tcnt", 17, 32'(s_tcnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
